// File: rtl/regfile_ext_sync_if.sv
// Bus bundle between the decode/writeback stages and regfile_ext_sync.
// The master drives read/write requests; the slave (register file) returns data.
interface regfile_ext_sync_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_size;
  logic              wr_signed;

  modport master (
    input  ready, rs_data, rt_data, rd_valid,
    output rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_size, wr_signed
  );

  modport slave (
    output ready, rs_data, rt_data, rd_valid,
    input  rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_size, wr_signed
  );
endinterface

// File: rtl/regfile_ext_sync.sv
// Clocked register file: two registered read ports with write bypass, one write
// port with load-size extension, and a post-reset clear sequencer that raises ready.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_ext_sync #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_ext_sync_if.slave   bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [NUM_REGS];

  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] ext_data;
  logic              sign_bit;
  logic              wr_accept;
  logic              rd_accept;
  logic              wr_addr_ok;
  logic              rs_force_zero;
  logic              rt_force_zero;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  // Shifting past DATA_W yields an all-ones mask, so word size passes through at DATA_W=32.
  always_comb begin
    keep_mask = '1;
    sign_bit  = 1'b0;
    case (bus.wr_size)
      2'd0: begin
        keep_mask = ~({DATA_W{1'b1}} << 8);
        sign_bit  = bus.wr_data[7];
      end
      2'd1: begin
        keep_mask = ~({DATA_W{1'b1}} << 16);
        sign_bit  = bus.wr_data[15];
      end
      2'd2: begin
        keep_mask = ~({DATA_W{1'b1}} << 32);
        sign_bit  = bus.wr_data[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase
    ext_data = (bus.wr_data & keep_mask) |
               ({DATA_W{sign_bit & bus.wr_signed}} & ~keep_mask);
  end

`ifdef REGFILE_ZERO_REG_EN
  assign wr_addr_ok    = (bus.wr_addr != '0);
  assign rs_force_zero = (bus.rs_addr == '0);
  assign rt_force_zero = (bus.rt_addr == '0);
`else
  assign wr_addr_ok    = 1'b1;
  assign rs_force_zero = 1'b0;
  assign rt_force_zero = 1'b0;
`endif

  assign wr_accept = (state == RUN) && bus.wr_en && wr_addr_ok;
  assign rd_accept = (state == RUN) && bus.rd_en;

  always_comb begin
    rs_next = mem[bus.rs_addr];
    rt_next = mem[bus.rt_addr];
    if (wr_accept && (bus.wr_addr == bus.rs_addr)) rs_next = ext_data;
    if (wr_accept && (bus.wr_addr == bus.rt_addr)) rt_next = ext_data;
    if (rs_force_zero) rs_next = '0;
    if (rt_force_zero) rt_next = '0;
  end

  // The array has no reset; the sequencer zeroes it instead, and an asserted reset
  // forces CLEAR so no user write can land in that cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept) begin
      mem[bus.wr_addr] <= ext_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      bus.ready    <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rs_data  <= '0;
      bus.rt_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          bus.rd_valid <= 1'b0;
          clr_cnt      <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          bus.ready    <= 1'b1;
          bus.rd_valid <= rd_accept;
          if (rd_accept) begin
            bus.rs_data <= rs_next;
            bus.rt_data <= rt_next;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_ext_sync.sv
// Directed self-checking bench for regfile_ext_sync (DATA_W=64, NUM_REGS=32).
// Expected register-0 behaviour follows REGFILE_ZERO_REG_EN when it is defined.
module tb_regfile_ext_sync;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_ext_sync_if #(.DATA_W(64), .NUM_REGS(32)) bus ();

  regfile_ext_sync #(.DATA_W(64), .NUM_REGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [63:0] R0_EXP = 64'h0;
`else
  localparam logic [63:0] R0_EXP = 64'h5;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [63:0] data,
                          input logic [1:0] size, input logic sgn);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = addr;
    bus.wr_data   = data;
    bus.wr_size   = size;
    bus.wr_signed = sgn;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    bus.rd_en   = 1'b1;
    bus.rs_addr = a;
    bus.rt_addr = b;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_state ready=%b rd_valid=%b rs=%h rt=%h required 0/0/0/0",
               bus.ready, bus.rd_valid, bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_clear();
    int cnt;
    cnt = 0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd3;
    bus.wr_data   = '1;
    bus.wr_size   = 2'd3;
    bus.wr_signed = 1'b0;
    bus.rd_en     = 1'b1;
    rst_n = 1'b1;
    while (!bus.ready && cnt < 40) begin
      tick();
      cnt++;
      if (!bus.ready) begin
        checks++;
        if (bus.rd_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL clear_rd_valid cycle %0d actual %b required 0", cnt, bus.rd_valid);
        end
      end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (cnt !== 32) begin
      errors++;
      $display("[TB] FAIL clear_length actual %0d cycles required 32", cnt);
    end
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 5'(31 - i));
      checks++;
      if (bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0 || bus.rd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL clear_read r%0d/r%0d rs=%h rt=%h valid=%b required 0/0/1",
                 i, 31 - i, bus.rs_data, bus.rt_data, bus.rd_valid);
      end
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clear_valid_pulse r%0d actual %b required 0", i, bus.rd_valid);
      end
    end
  endtask

  task automatic test_extension();
    do_write(5'd5,  64'h0000_0000_0000_00F0, 2'd0, 1'b1);
    do_write(5'd6,  64'h1234_5678_9ABC_8001, 2'd1, 1'b0);
    do_write(5'd7,  64'hAAAA_AAAA_8000_0000, 2'd2, 1'b1);
    do_write(5'd10, 64'h0123_4567_89AB_CDF0, 2'd0, 1'b0);
    do_write(5'd11, 64'h0000_0000_0000_8001, 2'd1, 1'b1);
    do_write(5'd12, 64'h8765_4321_7FFF_FFFF, 2'd2, 1'b1);
    do_write(5'd13, 64'hF000_0000_0000_0080, 2'd3, 1'b1);
    do_read(5'd5, 5'd6);
    checks++;
    if (bus.rs_data !== 64'hFFFF_FFFF_FFFF_FFF0 || bus.rt_data !== 64'h0000_0000_0000_8001) begin
      errors++;
      $display("[TB] FAIL ext_byte_s_half_u rs=%h rt=%h required FFFFFFFFFFFFFFF0/0000000000008001",
               bus.rs_data, bus.rt_data);
    end
    do_read(5'd7, 5'd10);
    checks++;
    if (bus.rs_data !== 64'hFFFF_FFFF_8000_0000 || bus.rt_data !== 64'h0000_0000_0000_00F0) begin
      errors++;
      $display("[TB] FAIL ext_word_s_byte_u rs=%h rt=%h required FFFFFFFF80000000/00000000000000F0",
               bus.rs_data, bus.rt_data);
    end
    do_read(5'd11, 5'd12);
    checks++;
    if (bus.rs_data !== 64'hFFFF_FFFF_FFFF_8001 || bus.rt_data !== 64'h0000_0000_7FFF_FFFF) begin
      errors++;
      $display("[TB] FAIL ext_half_s_word_pos rs=%h rt=%h required FFFFFFFFFFFF8001/000000007FFFFFFF",
               bus.rs_data, bus.rt_data);
    end
    do_read(5'd13, 5'd13);
    checks++;
    if (bus.rs_data !== 64'hF000_0000_0000_0080 || bus.rt_data !== 64'hF000_0000_0000_0080) begin
      errors++;
      $display("[TB] FAIL ext_full rs=%h rt=%h required F000000000000080 on both",
               bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_bypass();
    bus.rd_en   = 1'b1;
    bus.rs_addr = 5'd9;
    bus.rt_addr = 5'd9;
    do_write(5'd9, 64'hDEAD_BEEF_0000_0001, 2'd3, 1'b0);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rs_data !== 64'hDEAD_BEEF_0000_0001 || bus.rt_data !== 64'hDEAD_BEEF_0000_0001 ||
        bus.rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bypass_both rs=%h rt=%h valid=%b required DEADBEEF00000001 x2, 1",
               bus.rs_data, bus.rt_data, bus.rd_valid);
    end
    bus.rd_en   = 1'b1;
    bus.rs_addr = 5'd14;
    bus.rt_addr = 5'd5;
    do_write(5'd14, 64'h0000_0000_0000_0055, 2'd3, 1'b0);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rs_data !== 64'h55 || bus.rt_data !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      errors++;
      $display("[TB] FAIL bypass_rs_only rs=%h rt=%h required 0000000000000055/FFFFFFFFFFFFFFF0",
               bus.rs_data, bus.rt_data);
    end
    bus.rd_en   = 1'b1;
    bus.rs_addr = 5'd6;
    bus.rt_addr = 5'd15;
    do_write(5'd15, 64'h0000_0000_0000_FF80, 2'd0, 1'b1);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rs_data !== 64'h0000_0000_0000_8001 || bus.rt_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++;
      $display("[TB] FAIL bypass_rt_ext rs=%h rt=%h required 0000000000008001/FFFFFFFFFFFFFF80",
               bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_hold();
    do_read(5'd9, 5'd14);
    bus.rs_addr = 5'd6;
    bus.rt_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rs_data !== 64'hDEAD_BEEF_0000_0001 || bus.rt_data !== 64'h55 ||
          bus.rd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold cycle %0d rs=%h rt=%h valid=%b required DEADBEEF00000001/55/0",
                 i, bus.rs_data, bus.rt_data, bus.rd_valid);
      end
    end
  endtask

  task automatic test_zero_reg();
    bus.rd_en   = 1'b1;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    do_write(5'd0, 64'h5, 2'd3, 1'b0);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rs_data !== R0_EXP || bus.rt_data !== R0_EXP) begin
      errors++;
      $display("[TB] FAIL zero_reg_bypass rs=%h rt=%h required %h", bus.rs_data, bus.rt_data, R0_EXP);
    end
    do_read(5'd0, 5'd9);
    checks++;
    if (bus.rs_data !== R0_EXP || bus.rt_data !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("[TB] FAIL zero_reg_read rs=%h rt=%h required %h/DEADBEEF00000001",
               bus.rs_data, bus.rt_data, R0_EXP);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_read(5'd9, 5'd5);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_run_async ready=%b valid=%b rs=%h rt=%h required 0/0/0/0",
               bus.ready, bus.rd_valid, bus.rs_data, bus.rt_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_clear_ready actual %b required 0", bus.ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_clear_async ready=%b rs=%h rt=%h required 0/0/0",
               bus.ready, bus.rs_data, bus.rt_data);
    end
    tick();
    cnt = 0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd3;
    bus.wr_data   = 64'h1234_0000_0000_4321;
    bus.wr_size   = 2'd3;
    bus.wr_signed = 1'b0;
    rst_n = 1'b1;
    while (!bus.ready && cnt < 40) begin
      tick();
      cnt++;
    end
    bus.wr_en = 1'b0;
    checks++;
    if (cnt !== 32) begin
      errors++;
      $display("[TB] FAIL reclear_length actual %0d cycles required 32", cnt);
    end
    do_read(5'd5, 5'd9);
    checks++;
    if (bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reclear_contents rs=%h rt=%h required 0/0", bus.rs_data, bus.rt_data);
    end
    do_read(5'd3, 5'd13);
    checks++;
    if (bus.rs_data !== 64'h0 || bus.rt_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL clear_write_ignored rs=%h rt=%h required 0/0", bus.rs_data, bus.rt_data);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rs_addr   = '0;
    bus.rt_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_size   = 2'd0;
    bus.wr_signed = 1'b0;
    tick();
    tick();
    test_reset();
    test_clear();
    test_extension();
    test_bypass();
    test_hold();
    test_zero_reg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_ext_sync.md
Name: regfile_ext_sync

Overview:
- Parametrised, clocked successor to the 64-bit integer register file used by the uPower/MIPS datapaths.
- Provides two registered read ports and one write port.
- The write port applies load-size extension (byte/half/word/full, zero or sign) before the array write.
- Reads bypass a same-cycle write.
- A post-reset clear sequencer zeroes the array one entry per cycle; the block then asserts ready.
- Sits between the decode stage (read addresses) and the writeback mux (write data).

Parameters:
- DATA_W, 64, register width in bits; legal values 32 or 64.
- NUM_REGS, 32, number of registers; power of two, 2..64.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ready  output  1  high once the clear sequence has completed.
- rd_en  input  1  read request; samples rs_addr/rt_addr this cycle.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data, registered.
- rt_data  output  DATA_W  read port B data, registered.
- rd_valid  output  1  high the cycle after an accepted read.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write destination register.
- wr_data  input  DATA_W  raw write data (ALU result or memory load).
- wr_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = full.
- wr_signed  input  1  1 = sign-extend, 0 = zero-extend.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ready=0, rd_valid=0, rs_data=0, rt_data=0.
  - Clear counter=0; FSM enters CLEAR.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR and RUN.
  - CLEAR: writes 0 to entry clr_cnt each cycle and increments the counter. After entry NUM_REGS-1 is written, the next state is RUN. The sequence takes exactly NUM_REGS cycles after rst_n deasserts.
  - RUN: ready=1. The FSM stays in RUN until the next reset.
- During CLEAR:
  - wr_en is ignored; the request is dropped, not queued.
  - rd_en is ignored; rd_valid stays 0.
- Reset asserted mid-CLEAR or mid-RUN returns the FSM to CLEAR with clr_cnt=0. Any write in that cycle is discarded.
- Write extension, applied to wr_data before the array write (combinational):
  - size 0: keeps bits [7:0]; upper bits are zero, or copies of bit 7 if wr_signed=1.
  - size 1: keeps bits [15:0]; extends from bit 15.
  - size 2: keeps bits [31:0]; extends from bit 31. When DATA_W=32, this passes the data unchanged.
  - size 3: passes the full DATA_W unchanged; wr_signed is ignored.
- Write timing: in RUN with wr_en=1, the array entry wr_addr takes the extended value at the clock edge. There is one write per cycle, no write latency beyond that edge.
- Read timing:
  - In RUN with rd_en=1, rs_data/rt_data update at the next edge and rd_valid=1 for one cycle.
  - With rd_en=0, rs_data/rt_data hold their previous values and rd_valid=0.
- Bypass: if wr_en and rd_en are both accepted in the same cycle and wr_addr equals rs_addr, rs_data receives the extended write value rather than the stale array value. The same rule applies independently to rt_addr.
- rs_addr=rt_addr is legal; both outputs then carry identical data.
- Addresses are always in range, because NUM_REGS=2^ADDR_W.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including via bypass.
  - CLEAR still runs NUM_REGS cycles.
- Undefined: register 0 is an ordinary writable register (uPower r0 semantics).

Test Plan:
- Clear sequence: release rst_n with NUM_REGS=32 → ready=0 for 32 cycles then 1. Reading all 32 registers then returns 0 on both ports, with rd_valid pulsing once per read.
- Write extension: write 64'h0000_0000_0000_00F0 to r5 with size=0, signed=1 → r5 reads 64'hFFFF_FFFF_FFFF_FFF0. Write 64'h1234_5678_9ABC_8001 to r6 with size=1, signed=0 → r6 reads 64'h0000_0000_0000_8001. Write 64'hAAAA_AAAA_8000_0000 to r7 with size=2, signed=1 → r7 reads 64'hFFFF_FFFF_8000_0000.
- Bypass: in one cycle, write r9=64'hDEAD_BEEF_0000_0001 (size=3) with rs_addr=9 and rt_addr=9 → next cycle rs_data=rt_data=64'hDEAD_BEEF_0000_0001.
- Hold: read r9, then drop rd_en for 3 cycles → rs_data holds its value and rd_valid=0 for those 3 cycles.
- Reset mid-operation: assert rst_n low after 10 CLEAR cycles → outputs zero immediately. Release → ready rises 32 cycles later. A wr_en issued during CLEAR has no effect (register reads 0).
- Zero register:
  - With REGFILE_ZERO_REG_EN, write r0=64'h5 and read it with bypass active → returns 0.
  - Without the macro → returns 64'h5.
